operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 20 ++
 rtl/operand_fetch_regfile_2r1w.sv | 39 +++
 rtl/operand_fetch.sv | 150 +++++++++++++++
 tb/tb_operand_fetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared constants, output-stage state encoding and a saturating counter helper
// for the operand_fetch block.
package operand_fetch_pkg;

  localparam int OF_WIDTH = 64;
  localparam int OF_NREGS = 32;
  localparam int OF_AW    = $clog2(OF_NREGS);
  localparam int OF_SELW  = 8;
  localparam int OF_CNTW  = 16;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ofs_state_t;

  function automatic logic [OF_CNTW-1:0] sat_inc(input logic [OF_CNTW-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/operand_fetch_regfile_2r1w.sv
// Register file: two combinational read ports, one synchronous write port.
// Register 0 is hard-wired to zero and never written.
module regfile_2r1w
  import operand_fetch_pkg::*;
#(
  parameter int  WIDTH = OF_WIDTH,
  parameter int  NREGS = OF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [AW-1:0]    i_ra1,
  input  logic [AW-1:0]    i_ra2,
  output logic [WIDTH-1:0] o_rd1,
  output logic [WIDTH-1:0] o_rd2
);

  logic [WIDTH-1:0] r_mem [NREGS];

  // Storage update: reset clears every entry and masks the write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (i_we && (i_wa != {AW{1'b0}})) begin
      r_mem[i_wa] <= i_wd;
    end else begin
      r_mem <= r_mem;
    end
  end

  assign o_rd1 = (i_ra1 == {AW{1'b0}}) ? {WIDTH{1'b0}} : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == {AW{1'b0}}) ? {WIDTH{1'b0}} : r_mem[i_ra2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two source registers into a one-deep output bundle.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle write-back data to the bundle.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int  WIDTH = OF_WIDTH,
  parameter int  NREGS = OF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AW-1:0]      in_rs1,
  input  logic [AW-1:0]      in_rs2,
  input  logic [OF_SELW-1:0] in_sel,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [OF_SELW-1:0] out_sel,
  output logic               out_cin,
  input  logic               wb_en,
  input  logic [AW-1:0]      wb_rd,
  input  logic [WIDTH-1:0]   wb_data,
  output logic [OF_CNTW-1:0] issue_cnt
);

  ofs_state_t         r_state;
  ofs_state_t         w_state_nxt;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_we;
  logic [WIDTH-1:0]   w_rd1;
  logic [WIDTH-1:0]   w_rd2;
  logic [WIDTH-1:0]   w_opa;
  logic [WIDTH-1:0]   w_opb;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [OF_SELW-1:0] r_sel;
  logic               r_cin;
  logic [OF_CNTW-1:0] r_cnt;

  assign w_we     = wb_en && (wb_rd != {AW{1'b0}});
  assign w_accept = in_valid && in_ready;

  regfile_2r1w #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_we  (w_we),
    .i_wa  (wb_rd),
    .i_wd  (wb_data),
    .i_ra1 (in_rs1),
    .i_ra2 (in_rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

`ifdef OPERAND_FETCH_BYPASS_EN
  // Forward the write-back value when it targets a source read this cycle.
  always_comb begin
    w_opa = w_rd1;
    w_opb = w_rd2;
    if (w_we && (wb_rd == in_rs1)) begin
      w_opa = wb_data;
    end else begin
      w_opa = w_rd1;
    end
    if (w_we && (wb_rd == in_rs2)) begin
      w_opb = wb_data;
    end else begin
      w_opb = w_rd2;
    end
  end
`else
  assign w_opa = w_rd1;
  assign w_opb = w_rd2;
`endif

  // Output-stage state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output-stage next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
      ST_FULL:  w_state_nxt = (out_ready && !w_accept) ? ST_EMPTY : ST_FULL;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Output-stage state decode.
  always_comb begin
    w_out_valid = 1'b0;
    case (r_state)
      ST_EMPTY: w_out_valid = 1'b0;
      ST_FULL:  w_out_valid = 1'b1;
      default:  w_out_valid = 1'b0;
    endcase
  end

  assign in_ready  = !w_out_valid || out_ready;
  assign out_valid = w_out_valid;

  // Bundle payload loads only on accept, so a stalled bundle ignores write-backs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= {WIDTH{1'b0}};
      r_b   <= {WIDTH{1'b0}};
      r_sel <= {OF_SELW{1'b0}};
      r_cin <= 1'b0;
    end else if (w_accept) begin
      r_a   <= w_opa;
      r_b   <= w_opb;
      r_sel <= in_sel;
      r_cin <= in_cin;
    end else begin
      r_a   <= r_a;
      r_b   <= r_b;
      r_sel <= r_sel;
      r_cin <= r_cin;
    end
  end

  // Saturating count of bundles consumed by the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {OF_CNTW{1'b0}};
    end else if (w_out_valid && out_ready) begin
      r_cnt <= sat_inc(r_cnt);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_sel   = r_sel;
  assign out_cin   = r_cin;
  assign issue_cnt = r_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: behavioural register/bundle model with a
// per-cycle compare, directed scenarios with literal expectations, and random traffic.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [7:0]  in_sel;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [7:0]  out_sel;
  logic        out_cin;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [15:0] issue_cnt;

  int checks = 0;
  int errors = 0;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  operand_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_sel    (in_sel),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_sel   (out_sel),
    .out_cin   (out_cin),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural registers plus the single pending bundle.
  logic [63:0] m_regs [32];
  bit          m_valid;
  logic [63:0] m_a, m_b;
  logic [7:0]  m_sel;
  bit          m_cin;
  int          m_cnt;
  bit          model_live = 1'b0;

  function automatic logic [63:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 64'd0;
    if (BYP && wb_en && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  always @(posedge clk) begin
    bit acc, con;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 64'd0;
      m_valid = 1'b0; m_a = 64'd0; m_b = 64'd0; m_sel = 8'd0; m_cin = 1'b0; m_cnt = 0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      con = m_valid && out_ready;
      if (con && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (acc) begin
        m_a = m_read(in_rs1); m_b = m_read(in_rs2);
        m_sel = in_sel; m_cin = in_cin; m_valid = 1'b1;
      end else if (con) begin
        m_valid = 1'b0;
      end
      if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    end
    model_live = 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("m_out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      chk("m_in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
      chk("m_issue_cnt", {48'd0, issue_cnt}, m_cnt[63:0]);
      if (m_valid) begin
        chk("m_out_a", out_a, m_a);
        chk("m_out_b", out_b, m_b);
        chk("m_out_sel", {56'd0, out_sel}, {56'd0, m_sel});
        chk("m_out_cin", {63'd0, out_cin}, {63'd0, m_cin});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; wb_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_sel = 8'd0; in_cin = 1'b0;
    out_ready = 1'b1; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_issue_cnt", {48'd0, issue_cnt}, 64'd0);

    // Basic write and read
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h0123456789ABCDEF; step();
    wb_rd = 5'd6; wb_data = 64'd1; step();
    wb_en = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_sel = 8'h18; in_cin = 1'b1; step();
    chk("basic_a", out_a, 64'h0123456789ABCDEF);
    chk("basic_b", out_b, 64'd1);
    chk("basic_sel", {56'd0, out_sel}, 64'h18);
    chk("basic_cin", {63'd0, out_cin}, 64'd1);
    chk("basic_valid", {63'd0, out_valid}, 64'd1);

    // Stall with a new request pending and R5 rewritten
    in_valid = 1'b1; in_rs1 = 5'd6; in_rs2 = 5'd5; in_sel = 8'h55; in_cin = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'hAAAA;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      step();
      chk("stall_a", out_a, 64'h0123456789ABCDEF);
      chk("stall_sel", {56'd0, out_sel}, 64'h18);
    end
    chk("stall_cnt_before", {48'd0, issue_cnt}, 64'd0);
    idle(); out_ready = 1'b1; step();
    chk("stall_cnt_after", {48'd0, issue_cnt}, 64'd1);
    chk("stall_drain_valid", {63'd0, out_valid}, 64'd0);

    // Write/read collision on R7
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'hFF;
    in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd0; step();
    idle();
    chk("collide_a", out_a, BYP ? 64'hFF : 64'd0);
    in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd5; step();
    idle();
    chk("after_collide_a", out_a, 64'hFF);
    chk("r5_rewritten_b", out_b, 64'hAAAA);
    chk("collide_cnt", {48'd0, issue_cnt}, 64'd2);

    // Register 0 ignores writes
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hDEAD; step();
    wb_en = 1'b0; in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd0; step();
    idle();
    chk("r0_a", out_a, 64'd0);
    chk("r0_b", out_b, 64'd0);

    // Randomised traffic with narrow address range to provoke collisions
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_rs1    = 5'($urandom_range(0, 7));
      in_rs2    = 5'($urandom_range(0, 7));
      in_sel    = 8'($urandom);
      in_cin    = 1'($urandom);
      wb_en     = 1'($urandom);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = {32'($urandom), 32'($urandom)};
      step();
    end

    // Streaming from a fresh reset
    idle(); out_ready = 1'b1; rst = 1'b1; step(); rst = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h5555;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_rs1 = 5'($urandom_range(1, 31)); in_rs2 = 5'($urandom_range(1, 31));
      in_sel = 8'(i); step();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_sel", {56'd0, out_sel}, 64'(i));
    end
    idle(); step();
    chk("stream_cnt", {48'd0, issue_cnt}, 64'd10);
    chk("stream_drained", {63'd0, out_valid}, 64'd0);

    // Reset in the middle of a stalled stream
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd5; out_ready = 1'b0; step();
    chk("pre_rst_a", out_a, 64'h5555);
    rst = 1'b1; step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_cnt", {48'd0, issue_cnt}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; step();
    idle();
    chk("midrst_r5", out_a, 64'd0);
    chk("midrst_r6", out_b, 64'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
